instruction_fetch_stage: RTL



---
 rtl/miniMIPS_pkg.sv | 21 ++
 rtl/if_id_register.sv | 46 ++++
 rtl/instruction_fetch_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/miniMIPS_pkg.sv
// Shared miniMIPS fetch definitions: widths, reset PC, halt opcode, opcode field and fetch FSM encoding.
package miniMIPS_pkg;

  localparam int         PC_WIDTH    = 6;
  localparam int         INSTR_WIDTH = 32;
  localparam logic [5:0] RESET_PC    = 6'd0;
  localparam logic [5:0] HALT_OPCODE = 6'h3F;
  localparam int         OPCODE_MSB  = 31;
  localparam int         OPCODE_LSB  = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic is_halt_opcode(input logic [31:0] instr, input logic [5:0] halt_op);
    return instr[OPCODE_MSB:OPCODE_LSB] == halt_op;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load captures a fetched word, squash zeroes it, invalidate drops only valid.
module if_id_register #(
  parameter int PC_WIDTH    = 6,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   squash,
  input  logic                   invalidate,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   valid
);

  logic [INSTR_WIDTH-1:0] instr_r;
  logic [PC_WIDTH-1:0]    pc_r;
  logic                   valid_r;

  // Pipeline register update; no control asserted means hold
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r <= '0;
      pc_r    <= '0;
      valid_r <= 1'b0;
    end else if (squash) begin
      instr_r <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      instr_r <= load_instr;
      pc_r    <= load_pc;
      valid_r <= 1'b1;
    end else if (invalidate) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign instr = instr_r;
  assign pc    = pc_r;
  assign valid = valid_r;

endmodule

// File: rtl/instruction_fetch_stage.sv
// miniMIPS fetch stage: PC register, IDLE/RUN/HALTED fetch FSM and IF/ID register.
// Optional FETCH_COUNT_EN adds a saturating fetch_count output.
module instruction_fetch_stage #(
  parameter int                  PC_WIDTH    = miniMIPS_pkg::PC_WIDTH,
  parameter int                  INSTR_WIDTH = miniMIPS_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = miniMIPS_pkg::RESET_PC,
  parameter logic [5:0]          HALT_OPCODE = miniMIPS_pkg::HALT_OPCODE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    next_pc,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid,
  output logic                   halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]            fetch_count
`endif
);

  import miniMIPS_pkg::*;

  fetch_state_e        state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic                halted_r;
  logic                load_s;
  logic                squash_s;
  logic                invalidate_s;
  logic                halt_word_s;

  assign halt_word_s = is_halt_opcode(imem_data, HALT_OPCODE);

  // IF/ID control decode from the current state and pipeline requests
  always_comb begin
    load_s       = 1'b0;
    squash_s     = 1'b0;
    invalidate_s = 1'b0;
    case (state_r)
      IDLE: invalidate_s = 1'b1;
      RUN: begin
        if (flush) begin
          squash_s = 1'b1;
        end else if (!stall) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      // The halt word was visible for one cycle; drop valid unless stalled
      HALTED: begin
        if (flush || !stall) begin
          invalidate_s = 1'b1;
        end else begin
          invalidate_s = 1'b0;
        end
      end
      default: invalidate_s = 1'b1;
    endcase
  end

  // Fetch FSM and PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r  <= RUN;
          halted_r <= 1'b0;
        end
        RUN: begin
          if (flush) begin
            pc_r <= next_pc;
          end else if (stall) begin
            pc_r <= pc_r;
          end else if (halt_word_s) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
          end else begin
            pc_r <= next_pc;
          end
        end
        HALTED: begin
          if (flush) begin
            pc_r     <= next_pc;
            state_r  <= RUN;
            halted_r <= 1'b0;
          end else begin
            halted_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          pc_r     <= RESET_PC;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  if_id_register #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .squash    (squash_s),
    .invalidate(invalidate_s),
    .load_instr(imem_data),
    .load_pc   (pc_r),
    .instr     (if_id_instr),
    .pc        (if_id_pc),
    .valid     (if_id_valid)
  );

  assign pc        = pc_r;
  assign imem_addr = pc_r;
  assign halted    = halted_r;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_r;

  // Saturating count of cycles that capture a valid instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_r <= 16'd0;
    end else if (load_s && (fetch_count_r != 16'hFFFF)) begin
      fetch_count_r <= fetch_count_r + 16'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign fetch_count = fetch_count_r;
`endif

endmodule
